// File: rtl/key_event_ctrl_if.sv
// Valid/ready event port between key_event_ctrl and its consumer.
interface key_event_ctrl_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_key;
  logic [1:0] ev_code;

  modport master (output ev_valid, output ev_key, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_key, input ev_code, output ev_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// Debounces N active-low keys on a shared tick, runs press/hold/repeat per key and
// arbitrates the resulting events onto one registered valid/ready slot.
module key_event_ctrl #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEB_TICKS  = 5,
  parameter int unsigned LONG_TICKS = 1000,
  parameter int unsigned REP_TICKS  = 200
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     key_n,
  key_event_ctrl_if.master      ev,
  output logic [N_KEYS-1:0]     held,
  output logic                  ev_drop
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;
  localparam int unsigned HMAX = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam bit          DebOne = (DEB_TICKS <= 1);

  localparam logic [1:0] CodePress   = 2'd0;
  localparam logic [1:0] CodeLong    = 2'd1;
  localparam logic [1:0] CodeRepeat  = 2'd2;
  localparam logic [1:0] CodeRelease = 2'd3;

  typedef enum logic [2:0] {StIdle, StDbDn, StHeld, StRpt, StDbUp} key_st_e;

  logic [N_KEYS-1:0] s1_q, s2_q, p;
  logic [PW-1:0]     pre_q;
  logic              tick;

  key_st_e           st_q  [N_KEYS];
  key_st_e           st_d  [N_KEYS];
  logic [DW-1:0]     dc_q  [N_KEYS];
  logic [DW-1:0]     dc_d  [N_KEYS];
  logic [HW-1:0]     hc_q  [N_KEYS];
  logic [HW-1:0]     hc_d  [N_KEYS];
  logic [N_KEYS-1:0] ret_q, ret_d;
  logic [3:0]        raise  [N_KEYS];
  logic [3:0]        pend_q [N_KEYS];
  logic [3:0]        pend_d [N_KEYS];

  logic       sel_found;
  logic [2:0] sel_key;
  logic [1:0] sel_code;
  logic       load, drop_d;
  logic       ev_valid_q, ev_drop_q;
  logic [2:0] ev_key_q;
  logic [1:0] ev_code_q;

  // Synchronizer idles at 1 so reset looks like all keys released.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
    end
  end

  assign p = ~s2_q;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
    end
  end

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      st_d[k]  = st_q[k];
      dc_d[k]  = dc_q[k];
      hc_d[k]  = hc_q[k];
      ret_d[k] = ret_q[k];
      raise[k] = 4'b0000;
      if (tick) begin
        unique case (st_q[k])
          StIdle: begin
            if (p[k]) begin
              if (DebOne) begin
                st_d[k]             = StHeld;
                hc_d[k]             = '0;
                raise[k][CodePress] = 1'b1;
              end else begin
                st_d[k] = StDbDn;
                dc_d[k] = DW'(1);
              end
            end
          end
          StDbDn: begin
            if (!p[k]) begin
              st_d[k] = StIdle;
              dc_d[k] = '0;
            end else if ((dc_q[k] + DW'(1)) == DW'(DEB_TICKS)) begin
              st_d[k]             = StHeld;
              dc_d[k]             = '0;
              hc_d[k]             = '0;
              raise[k][CodePress] = 1'b1;
            end else begin
              dc_d[k] = dc_q[k] + DW'(1);
            end
          end
          StHeld, StRpt: begin
            if (!p[k]) begin
              ret_d[k] = (st_q[k] == StRpt);
              if (DebOne) begin
                st_d[k]               = StIdle;
                hc_d[k]               = '0;
                raise[k][CodeRelease] = 1'b1;
              end else begin
                st_d[k] = StDbUp;
                dc_d[k] = DW'(1);
              end
            end else if ((hc_q[k] + HW'(1)) ==
                         ((st_q[k] == StHeld) ? HW'(LONG_TICKS) : HW'(REP_TICKS))) begin
              hc_d[k] = '0;
              st_d[k] = StRpt;
              raise[k][(st_q[k] == StHeld) ? CodeLong : CodeRepeat] = 1'b1;
            end else begin
              hc_d[k] = hc_q[k] + HW'(1);
            end
          end
          StDbUp: begin
            // hc is left untouched so a bounce resumes the hold timing where it stopped.
            if (p[k]) begin
              st_d[k] = ret_q[k] ? StRpt : StHeld;
              dc_d[k] = '0;
            end else if ((dc_q[k] + DW'(1)) == DW'(DEB_TICKS)) begin
              st_d[k]               = StIdle;
              dc_d[k]               = '0;
              hc_d[k]               = '0;
              raise[k][CodeRelease] = 1'b1;
            end else begin
              dc_d[k] = dc_q[k] + DW'(1);
            end
          end
          default: st_d[k] = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      held[k] = (st_q[k] == StHeld) || (st_q[k] == StRpt) || (st_q[k] == StDbUp);
    end
  end

  // Fixed priority: lowest key first, then PRESS > LONG > REPEAT > RELEASE.
  always_comb begin
    sel_found = 1'b0;
    sel_key   = '0;
    sel_code  = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (!sel_found && pend_q[k][c]) begin
          sel_found = 1'b1;
          sel_key   = 3'(k);
          sel_code  = 2'(c);
        end
      end
    end
  end

  assign load = !ev_valid_q || ev.ev_ready;

  always_comb begin
    logic take;
    drop_d = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      for (int c = 0; c < 4; c++) begin
        take = load && sel_found && (sel_key == 3'(k)) && (sel_code == 2'(c));
        pend_d[k][c] = raise[k][c] | (pend_q[k][c] & ~take);
        if (raise[k][c] && pend_q[k][c] && !take) begin
          drop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]   <= StIdle;
        dc_q[k]   <= '0;
        hc_q[k]   <= '0;
        pend_q[k] <= 4'b0000;
      end
      ret_q <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]   <= st_d[k];
        dc_q[k]   <= dc_d[k];
        hc_q[k]   <= hc_d[k];
        pend_q[k] <= pend_d[k];
      end
      ret_q <= ret_d;
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_code_q  <= '0;
      ev_drop_q  <= 1'b0;
    end else begin
      ev_drop_q <= drop_d;
      if (load) begin
        ev_valid_q <= sel_found;
        if (sel_found) begin
          ev_key_q  <= sel_key;
          ev_code_q <= sel_code;
        end
      end
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_key   = ev_key_q;
  assign ev.ev_code  = ev_code_q;
  assign ev_drop     = ev_drop_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: reset, press/release, bounce, long/repeat,
// arbitration and drop behaviour with hand-computed expectations.
module tb_key_event_ctrl;

  localparam int unsigned NK = 4;

  logic          clk50M = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] held;
  logic          ev_drop;

  key_event_ctrl_if ev_if ();

  key_event_ctrl #(
    .N_KEYS    (NK),
    .TICK_DIV  (10),
    .DEB_TICKS (4),
    .LONG_TICKS(20),
    .REP_TICKS (5)
  ) dut (
    .clk50M (clk50M),
    .rst    (rst),
    .key_n  (key_n),
    .ev     (ev_if.master),
    .held   (held),
    .ev_drop(ev_drop)
  );

  always #5 clk50M = ~clk50M;

  typedef struct {
    int unsigned key;
    int unsigned code;
    int unsigned t;
  } ev_t;

  ev_t         evq[$];
  int unsigned cyc = 0;
  int unsigned n_drop = 0;
  int unsigned n_total = 0;
  int unsigned n_bad = 0;
  bit          seen0 = 1'b0;

  always @(posedge clk50M) cyc <= cyc + 1;

  // Accepted events, drop pulses and key 0 level are observed mid-cycle.
  always @(negedge clk50M) begin
    if (!rst) begin
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        evq.push_back('{key: ev_if.ev_key, code: ev_if.ev_code, t: cyc});
      end
      if (ev_drop) n_drop = n_drop + 1;
      if (held[0]) seen0 = 1'b1;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  task automatic check_ev(input string tag, input int idx, input int unsigned key,
                          input int unsigned code);
    if (idx < evq.size()) begin
      check({tag, "_key"}, evq[idx].key, key);
      check({tag, "_code"}, evq[idx].code, code);
    end else begin
      check({tag, "_present"}, 0, 1);
    end
  endtask

  int unsigned lat;
  bit          found;
  int unsigned exp_code[6] = '{0, 1, 2, 2, 2, 3};
  int unsigned exp_gap[4]  = '{200, 50, 50, 50};

  initial begin
    rst             = 1'b1;
    key_n           = 4'b0000;
    ev_if.ev_ready  = 1'b1;
    step(5);
    @(negedge clk50M);
    check("rst_valid", ev_if.ev_valid, 0);
    check("rst_key", ev_if.ev_key, 0);
    check("rst_code", ev_if.ev_code, 0);
    check("rst_held", held, 0);
    check("rst_drop", ev_drop, 0);

    key_n = 4'b1111;
    step(1);
    rst = 1'b0;
    step(1000);
    check("idle_events", evq.size(), 0);
    check("idle_drops", n_drop, 0);

    // Clean press/release of key 2.
    key_n[2] = 1'b0;
    found    = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk50M);
      if (!found && held[2]) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check("k2_held_in_52", (found && lat <= 52) ? 1 : 0, 1);
    step(40);
    check("k2_press_cnt", evq.size(), 1);
    check_ev("k2_press", 0, 2, 0);
    evq.delete();
    key_n[2] = 1'b1;
    step(100);
    check("k2_rel_cnt", evq.size(), 1);
    check_ev("k2_rel", 0, 2, 3);
    check("k2_held_low", held[2], 0);
    evq.delete();

    // Bounce shorter than the debounce window.
    seen0    = 1'b0;
    key_n[0] = 1'b0;
    step(25);
    key_n[0] = 1'b1;
    step(15);
    key_n[0] = 1'b0;
    step(25);
    key_n[0] = 1'b1;
    step(100);
    check("bounce_events", evq.size(), 0);
    check("bounce_held", seen0, 0);

    // Long press with repeats on key 1.
    key_n[1] = 1'b0;
    step(400);
    key_n[1] = 1'b1;
    step(100);
    check("lr_cnt", evq.size(), 6);
    for (int i = 0; i < 6; i++) check_ev($sformatf("lr%0d", i), i, 1, exp_code[i]);
    if (evq.size() >= 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("lr_gap%0d", i), evq[i + 1].t - evq[i].t, exp_gap[i]);
      end
    end
    evq.delete();

    // Simultaneous presses with the consumer stalled.
    ev_if.ev_ready = 1'b0;
    key_n[3]       = 1'b0;
    key_n[0]       = 1'b0;
    step(100);
    @(negedge clk50M);
    check("arb_valid", ev_if.ev_valid, 1);
    check("arb_key", ev_if.ev_key, 0);
    check("arb_code", ev_if.ev_code, 0);
    step(20);
    @(negedge clk50M);
    check("arb_stable_key", ev_if.ev_key, 0);
    check("arb_stable_code", ev_if.ev_code, 0);
    check("arb_none_taken", evq.size(), 0);
    step(1);
    ev_if.ev_ready = 1'b1;
    step(5);
    check("arb_cnt", evq.size(), 2);
    check_ev("arb0", 0, 0, 0);
    check_ev("arb1", 1, 3, 0);
    if (evq.size() >= 2) check("arb_back2back", evq[1].t - evq[0].t, 1);
    evq.delete();
    key_n = 4'b1111;
    step(100);
    check("arb_rel_cnt", evq.size(), 2);
    check_ev("arb_rel0", 0, 0, 3);
    check_ev("arb_rel1", 1, 3, 3);
    evq.delete();

    // Two full cycles of key 1 while stalled: PRESS1 sits in the slot, RELEASE1 and
    // PRESS2 queue as pending, RELEASE2 collides with the pending RELEASE.
    n_drop         = 0;
    ev_if.ev_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      key_n[1] = 1'b0;
      step(100);
      key_n[1] = 1'b1;
      step(100);
    end
    check("drop_pulses", n_drop, 1);
    ev_if.ev_ready = 1'b1;
    step(20);
    check("drop_cnt", evq.size(), 3);
    check_ev("drop0", 0, 1, 0);
    check_ev("drop1", 1, 1, 0);
    check_ev("drop2", 2, 1, 3);
    evq.delete();

    // Reset while a key is held: no RELEASE afterwards.
    key_n[2] = 1'b0;
    step(100);
    check("mid_held_before", held[2], 1);
    evq.delete();
    rst = 1'b1;
    #1;
    check("mid_held_rst", held, 0);
    check("mid_valid_rst", ev_if.ev_valid, 0);
    key_n = 4'b1111;
    step(3);
    rst = 1'b0;
    step(200);
    check("mid_no_release", evq.size(), 0);
    check("mid_held_after", held, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
